// File: rtl/vram_pkg.sv
// -----------------------------------------------------------------------------
// vram_pkg
// Shared definitions for the pixel-RAM arbiter slice:
//   - 640x480 visible-window bounds in VGA counter coordinates
//   - default address / data / write-buffer sizes
//   - CPU request FSM state encoding
//   - helper that decides whether a counter pair falls in the display slot
// -----------------------------------------------------------------------------
package vram_pkg;

  // Default widths: address is {row[8:0], col[9:0]}, pixel is bbbb_gggg_rrrr.
  localparam int DEF_ADDR_W     = 19;
  localparam int DEF_DATA_W     = 12;
  localparam int DEF_FIFO_DEPTH = 4;

  // Visible window. START is inclusive, END is exclusive.
  localparam logic [9:0] H_DISP_START = 10'd143;
  localparam logic [9:0] H_DISP_END   = 10'd783;
  localparam logic [9:0] V_DISP_START = 10'd35;
  localparam logic [9:0] V_DISP_END   = 10'd515;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_PEND = 2'd1,
    ST_RD_DATA = 2'd2
  } cpu_state_e;

  // True while the scanout owns the RAM port.
  function automatic logic in_disp(input logic [9:0] h, input logic [9:0] v);
    return (h >= H_DISP_START) && (h < H_DISP_END) &&
           (v >= V_DISP_START) && (v < V_DISP_END);
  endfunction

endpackage

// File: rtl/vram_wr_fifo.sv
// -----------------------------------------------------------------------------
// vram_wr_fifo
// Synchronous FIFO that buffers CPU pixel writes as {addr, wdata} pairs until
// the RAM port is free. Head entry is presented combinationally so the arbiter
// can drive RAM and pop in the same cycle.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset (clears contents)
//   i_push          write {i_push_addr, i_push_data} at the tail
//   i_pop           drop the head entry
//   o_full/o_empty  occupancy flags
//   o_level         occupancy, 0..DEPTH
//   o_head_addr/o_head_data  oldest entry
// -----------------------------------------------------------------------------
module vram_wr_fifo
  import vram_pkg::*;
#(
  parameter int AW    = DEF_ADDR_W,
  parameter int DW    = DEF_DATA_W,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [AW-1:0]            i_push_addr,
  input  logic [DW-1:0]            i_push_data,
  input  logic                     i_pop,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic [AW-1:0]            o_head_addr,
  output logic [DW-1:0]            o_head_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_LEVEL = (PTR_W + 1)'(DEPTH);

  logic [AW+DW-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_level;

  logic             w_push_ok;
  logic             w_pop_ok;
  logic [AW+DW-1:0] w_head;

  // Guard against overflow / underflow even if the caller misbehaves.
  assign w_push_ok = i_push && (r_level != FULL_LEVEL);
  assign w_pop_ok  = i_pop  && (r_level != '0);

  assign o_full      = (r_level == FULL_LEVEL);
  assign o_empty     = (r_level == '0);
  assign o_level     = r_level;
  assign w_head      = r_mem[r_rd_ptr];
  assign o_head_addr = w_head[AW+DW-1:DW];
  assign o_head_data = w_head[DW-1:0];

  // Storage write at the tail; reset discards buffered entries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push_ok) begin
      r_mem[r_wr_ptr] <= {i_push_addr, i_push_data};
    end else begin
      r_mem[r_wr_ptr] <= r_mem[r_wr_ptr];
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end else begin
        r_wr_ptr <= r_wr_ptr;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end else begin
        r_rd_ptr <= r_rd_ptr;
      end
    end
  end

  // Occupancy: simultaneous push and pop leaves the level unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_level <= '0;
    end else begin
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_level <= r_level + (PTR_W + 1)'(1);
        2'b01:   r_level <= r_level - (PTR_W + 1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// -----------------------------------------------------------------------------
// vram_arbiter
// Single-port pixel-RAM arbiter between the VGA scanout and a CPU port.
// Per-cycle priority: display fetch > write-buffer drain > pending CPU read.
// CPU writes are buffered and drained in blanking; a CPU read waits until the
// buffer is empty so it always observes every earlier write.
//
// Ports:
//   clk, rst                 pixel clock, asynchronous active-high reset
//   i_h_count, i_v_count     VGA counters (0-799, 0-524)
//   o_vga_din                pixel to VGA, straight from RAM read data
//   i_cpu_req_*              CPU request (valid/ready handshake, we, addr, wdata)
//   o_cpu_req_ready          request accepted when valid && ready
//   o_cpu_rsp_valid          one-cycle read-data pulse
//   o_cpu_rsp_rdata          read data, held until the next response
//   o_ram_addr/we/wdata      RAM port, combinational
//   i_ram_rdata              RAM read data, one cycle after the address
//   o_fifo_level             write buffer occupancy
// -----------------------------------------------------------------------------
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [9:0]                    i_h_count,
  input  logic [9:0]                    i_v_count,
  output logic [DATA_W-1:0]             o_vga_din,
  input  logic                          i_cpu_req_valid,
  output logic                          o_cpu_req_ready,
  input  logic                          i_cpu_req_we,
  input  logic [ADDR_W-1:0]             i_cpu_req_addr,
  input  logic [DATA_W-1:0]             i_cpu_req_wdata,
  output logic                          o_cpu_rsp_valid,
  output logic [DATA_W-1:0]             o_cpu_rsp_rdata,
  output logic [ADDR_W-1:0]             o_ram_addr,
  output logic                          o_ram_we,
  output logic [DATA_W-1:0]             o_ram_wdata,
  input  logic [DATA_W-1:0]             i_ram_rdata,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);

  cpu_state_e r_state;
  cpu_state_e w_state_nxt;

  logic [ADDR_W-1:0] r_rd_addr;
  logic [DATA_W-1:0] r_rsp_rdata;

  logic              w_disp;
  logic [8:0]        w_row;
  logic [9:0]        w_col;

  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [ADDR_W-1:0] w_head_addr;
  logic [DATA_W-1:0] w_head_data;
  logic              w_push;
  logic              w_pop;

  logic              w_ready;
  logic              w_rd_accept;
  logic              w_rd_issue;
  logic              w_rsp_valid;

  logic [ADDR_W-1:0] w_ram_addr;
  logic              w_ram_we;
  logic [DATA_W-1:0] w_ram_wdata;

  // Display slot and its RAM coordinates. Only the low 9 row bits matter:
  // visible rows are 0..479.
  assign w_disp = in_disp(i_h_count, i_v_count);
  assign w_row  = 9'(i_v_count - V_DISP_START);
  assign w_col  = i_h_count - H_DISP_START;

  vram_wr_fifo #(
    .AW    (ADDR_W),
    .DW    (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_wr_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_addr (i_cpu_req_addr),
    .i_push_data (i_cpu_req_wdata),
    .i_pop       (w_pop),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty),
    .o_level     (o_fifo_level),
    .o_head_addr (w_head_addr),
    .o_head_data (w_head_data)
  );

  // RAM port owner for this cycle. A read only issues with the buffer empty,
  // which is what keeps reads ordered behind earlier writes.
  always_comb begin
    w_ram_addr  = '0;
    w_ram_we    = 1'b0;
    w_ram_wdata = '0;
    w_pop       = 1'b0;
    w_rd_issue  = 1'b0;
    if (w_disp) begin
      w_ram_addr = {w_row, w_col};
    end else if (!w_fifo_empty) begin
      w_ram_addr  = w_head_addr;
      w_ram_we    = 1'b1;
      w_ram_wdata = w_head_data;
      w_pop       = 1'b1;
    end else if (r_state == ST_RD_PEND) begin
      w_ram_addr = r_rd_addr;
      w_rd_issue = 1'b1;
    end else begin
      w_ram_addr = '0;
    end
  end

  // CPU request FSM: next state and handshake controls.
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_push      = 1'b0;
    w_rd_accept = 1'b0;
    w_rsp_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_ready = !(i_cpu_req_we && w_fifo_full);
        if (i_cpu_req_valid && w_ready && !rst) begin
          if (i_cpu_req_we) begin
            w_push = 1'b1;
          end else begin
            w_rd_accept = 1'b1;
            w_state_nxt = ST_RD_PEND;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RD_PEND: begin
        if (w_rd_issue) begin
          w_state_nxt = ST_RD_DATA;
        end else begin
          w_state_nxt = ST_RD_PEND;
        end
      end
      ST_RD_DATA: begin
        // RAM data for the issued read is on i_ram_rdata now.
        w_rsp_valid = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM state register; reset abandons any outstanding read silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Read address is sampled only on the accept edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_addr <= '0;
    end else if (w_rd_accept) begin
      r_rd_addr <= i_cpu_req_addr;
    end else begin
      r_rd_addr <= r_rd_addr;
    end
  end

  // Holds the last response data after the valid pulse ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_rdata <= '0;
    end else if (r_state == ST_RD_DATA) begin
      r_rsp_rdata <= i_ram_rdata;
    end else begin
      r_rsp_rdata <= r_rsp_rdata;
    end
  end

  // During the pulse the RAM data is forwarded so data and valid coincide.
  assign o_cpu_rsp_rdata = (r_state == ST_RD_DATA) ? i_ram_rdata : r_rsp_rdata;
  assign o_cpu_rsp_valid = w_rsp_valid;
  assign o_cpu_req_ready = w_ready && !rst;

  assign o_ram_addr  = w_ram_addr;
  assign o_ram_we    = w_ram_we;
  assign o_ram_wdata = w_ram_wdata;
  assign o_vga_din   = i_ram_rdata;

endmodule

// File: tb/tb_vram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vram_arbiter
// Directed bench for vram_arbiter with a behavioural synchronous pixel RAM.
// VGA counters are driven by the bench, either held or free-running.
// -----------------------------------------------------------------------------
module tb_vram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  h;
  logic [9:0]  v;
  logic [11:0] vga_din;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [18:0] req_addr;
  logic [11:0] req_wdata;
  logic        rsp_valid;
  logic [11:0] rsp_rdata;
  logic [18:0] ram_addr;
  logic        ram_we;
  logic [11:0] ram_wdata;
  logic [11:0] ram_rdata;
  logic [2:0]  fifo_level;

  logic [11:0] mem [0:524287];
  logic        run;
  int          n_checks = 0;
  int          n_pass   = 0;

  always #5 clk = ~clk;

  vram_arbiter dut (
    .clk             (clk),
    .rst             (rst),
    .i_h_count       (h),
    .i_v_count       (v),
    .o_vga_din       (vga_din),
    .i_cpu_req_valid (req_valid),
    .o_cpu_req_ready (req_ready),
    .i_cpu_req_we    (req_we),
    .i_cpu_req_addr  (req_addr),
    .i_cpu_req_wdata (req_wdata),
    .o_cpu_rsp_valid (rsp_valid),
    .o_cpu_rsp_rdata (rsp_rdata),
    .o_ram_addr      (ram_addr),
    .o_ram_we        (ram_we),
    .o_ram_wdata     (ram_wdata),
    .i_ram_rdata     (ram_rdata),
    .o_fifo_level    (fifo_level)
  );

  // Synchronous-read pixel RAM, read-before-write.
  initial begin
    for (int i = 0; i < 524288; i++) mem[i] = 12'h000;
    ram_rdata = 12'h000;
    forever begin
      @(posedge clk);
      ram_rdata <= mem[ram_addr];
      if (ram_we) mem[ram_addr] <= ram_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // One clock; counters advance just after the edge when free-running.
  task automatic tick();
    @(posedge clk);
    #1;
    if (run) begin
      if (h == 10'd799) begin
        h = 10'd0;
        v = (v == 10'd524) ? 10'd0 : v + 10'd1;
      end else begin
        h = h + 10'd1;
      end
    end
    #1;
  endtask

  task automatic set_req(input logic vld, input logic we, input logic [18:0] a, input logic [11:0] d);
    req_valid = vld;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    #1;
  endtask

  initial begin
    int bad;
    int budget;
    logic [18:0] exp_addr;

    rst = 1'b1; run = 1'b0; h = 10'd790; v = 10'd100;
    set_req(1'b1, 1'b1, 19'h00005, 12'hF00);

    // ---- reset, then first write outside disp ----
    repeat (3) tick();
    check("rst_ready", req_ready, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_level", fifo_level, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    rst = 1'b0; #1;
    check("post_rst_ready", req_ready, 1);
    tick();
    set_req(1'b0, 1'b0, 19'h0, 12'h0);
    check("wr_lat_we", ram_we, 1);
    check("wr_lat_addr", ram_addr, 32'h5);
    check("wr_lat_data", ram_wdata, 32'hF00);
    check("wr_lat_level", fifo_level, 1);
    tick();
    check("drain_level", fifo_level, 0);
    check("idle_we", ram_we, 0);
    check("idle_addr", ram_addr, 0);
    check("ram_mem5", mem[5], 32'hF00);

    // ---- display addressing ----
    h = 10'd143; v = 10'd35; #1;
    check("disp_first_addr", ram_addr, 0);
    check("disp_first_we", ram_we, 0);
    h = 10'd782; v = 10'd514; #1;
    exp_addr = {9'd479, 10'd639};
    check("disp_last_addr", ram_addr, {13'd0, exp_addr});
    check("disp_last_we", ram_we, 0);
    h = 10'd148; v = 10'd35; #1;
    check("disp_pix5_addr", ram_addr, 32'h5);
    tick();
    check("vga_din", vga_din, 32'hF00);
    h = 10'd783; v = 10'd100; #1;
    check("release_addr", ram_addr, 0);
    check("release_we", ram_we, 0);

    // ---- minimum read latency in vertical blanking ----
    h = 10'd100; v = 10'd520;
    set_req(1'b1, 1'b0, 19'h00005, 12'h0);
    check("rd_min_ready", req_ready, 1);
    tick();
    set_req(1'b0, 1'b0, 19'h0, 12'h0);
    check("rd_min_issue_addr", ram_addr, 32'h5);
    check("rd_min_issue_we", ram_we, 0);
    check("rd_min_no_rsp", rsp_valid, 0);
    tick();
    check("rd_min_rsp_valid", rsp_valid, 1);
    check("rd_min_rsp_data", rsp_rdata, 32'hF00);
    tick();
    check("rd_min_pulse_end", rsp_valid, 0);
    check("rd_min_hold", rsp_rdata, 32'hF00);

    // ---- burst of 5 writes in the visible window ----
    h = 10'd200; v = 10'd100; run = 1'b1;
    for (int k = 0; k < 4; k++) begin
      set_req(1'b1, 1'b1, 19'h00100 + 19'(k), 12'h010 + 12'(k));
      check("burst_ready", req_ready, 1);
      tick();
    end
    set_req(1'b1, 1'b1, 19'h00104, 12'h014);
    check("burst_full_level", fifo_level, 4);
    check("burst_full_ready", req_ready, 0);
    bad = 0; budget = 0;
    while (h != 10'd783 && budget < 1000) begin
      if (req_ready || ram_we || fifo_level != 3'd4) bad++;
      tick();
      budget++;
    end
    check("burst_hold", bad, 0);
    check("burst_reach_783", h, 783);
    for (int k = 0; k < 4; k++) begin
      check("burst_drain_we", ram_we, 1);
      check("burst_drain_addr", ram_addr, 32'h100 + k);
      check("burst_drain_data", ram_wdata, 32'h010 + k);
      check("burst_drain_level", fifo_level, (k == 0) ? 4 : ((k == 3) ? 2 : 3));
      check("burst_drain_ready", req_ready, (k == 0) ? 0 : 1);
      tick();
      if (k == 1) set_req(1'b0, 1'b0, 19'h0, 12'h0);
    end
    check("burst5_we", ram_we, 1);
    check("burst5_addr", ram_addr, 32'h104);
    check("burst5_data", ram_wdata, 32'h014);
    tick();
    check("burst_empty_level", fifo_level, 0);
    check("burst_empty_we", ram_we, 0);
    for (int k = 0; k < 5; k++) check("burst_mem", mem[32'h100 + k], 32'h010 + k);

    // ---- read after write ----
    h = 10'd300; v = 10'd100;
    set_req(1'b1, 1'b1, 19'h12345, 12'hABC);
    check("raw_wr_ready", req_ready, 1);
    tick();
    set_req(1'b1, 1'b0, 19'h12345, 12'h0);
    check("raw_rd_ready", req_ready, 1);
    tick();
    set_req(1'b0, 1'b0, 19'h0, 12'h0);
    check("raw_pend_ready", req_ready, 0);
    bad = 0; budget = 0;
    while (h != 10'd783 && budget < 1000) begin
      if (rsp_valid || ram_we) bad++;
      tick();
      budget++;
    end
    check("raw_wait", bad, 0);
    check("raw_drain_we", ram_we, 1);
    check("raw_drain_addr", ram_addr, 32'h12345);
    check("raw_drain_data", ram_wdata, 32'hABC);
    check("raw_no_early_rsp", rsp_valid, 0);
    tick();
    check("raw_issue_addr", ram_addr, 32'h12345);
    check("raw_issue_we", ram_we, 0);
    check("raw_issue_no_rsp", rsp_valid, 0);
    tick();
    check("raw_rsp_valid", rsp_valid, 1);
    check("raw_rsp_data", rsp_rdata, 32'hABC);
    tick();
    check("raw_rsp_pulse_end", rsp_valid, 0);
    check("raw_rsp_hold", rsp_rdata, 32'hABC);
    check("raw_idle_ready", req_ready, 1);

    // ---- reset while a read is pending behind buffered writes ----
    h = 10'd300; v = 10'd100;
    set_req(1'b1, 1'b1, 19'h00200, 12'h555);
    tick();
    set_req(1'b1, 1'b1, 19'h00201, 12'h666);
    tick();
    set_req(1'b1, 1'b0, 19'h00200, 12'h0);
    tick();
    set_req(1'b0, 1'b0, 19'h0, 12'h0);
    repeat (5) tick();
    check("rstrd_pend_ready", req_ready, 0);
    check("rstrd_pend_level", fifo_level, 2);
    rst = 1'b1; #1;
    check("rstrd_ready", req_ready, 0);
    check("rstrd_level", fifo_level, 0);
    check("rstrd_rsp_valid", rsp_valid, 0);
    tick();
    rst = 1'b0; #1;
    check("rstrd_idle_ready", req_ready, 1);
    bad = 0; budget = 0;
    while (h != 10'd790 && budget < 1000) begin
      if (rsp_valid || ram_we) bad++;
      tick();
      budget++;
    end
    check("rstrd_quiet", bad, 0);
    check("rstrd_reach_790", h, 790);
    check("rstrd_mem200", mem[32'h200], 0);
    check("rstrd_mem201", mem[32'h201], 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
